// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a small decoupling queue. Owns the PC, reads
// instruction memory one word per cycle (combinational-read memory), and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO. The head entry is offered
// to decode together with precomputed B and CBZ/B.cond branch targets. A
// redirect flushes the queue and reloads the PC.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   imem_addr      out  current PC (address presented to instruction memory)
//   imem_rdata     in   instruction at imem_addr, valid in the same cycle
//   redirect_valid in   flush request / taken branch
//   redirect_pc    in   new PC, bits [1:0] ignored
//   out_valid      out  head entry available
//   out_ready      in   decode accepts the head entry this cycle
//   out_pc         out  PC of head entry (0 when out_valid=0)
//   out_instr      out  head instruction (0 when out_valid=0)
//   out_target_b   out  out_pc + (sext(instr[25:0]) << 2)
//   out_target_cb  out  out_pc + (sext(instr[23:5]) << 2)
//
// Handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the head entry and
// its targets hold steady. out_valid never depends on out_ready.
// ----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int unsigned              ADDR_W   = 64,
    parameter int unsigned              INSTR_W  = 32,
    parameter int unsigned              DEPTH    = 4,
    parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_target_b,
    output logic [ADDR_W-1:0]  out_target_cb
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_store    [DEPTH];
    logic [INSTR_W-1:0] instr_store [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               deq;
    logic               push;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  imm_b;
    logic [ADDR_W-1:0]  imm_cb;

    // The low two bits of the redirect address are deliberately dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign deq       = out_valid & out_ready;
    // A full queue still accepts a new word when the head leaves in the same
    // cycle, which keeps throughput at one instruction per cycle.
    assign push      = !redirect_valid & (!full | deq);

    assign imem_addr = pc_q;

    // Control state: PC, pointers, occupancy. Reset beats redirect, redirect
    // beats push/pop (a same-cycle handshake is simply flushed away).
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc_q   <= {redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pc_q   <= pc_q + ADDR_W'(4);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_store[wr_ptr]    <= pc_q;
            instr_store[wr_ptr] <= imem_rdata;
        end
    end

    assign head_pc    = pc_store[rd_ptr];
    assign head_instr = instr_store[rd_ptr];

    // Immediates already scaled by 4 and sign-extended to ADDR_W.
    assign imm_b  = {{(ADDR_W-28){head_instr[25]}}, head_instr[25:0], 2'b00};
    assign imm_cb = {{(ADDR_W-21){head_instr[23]}}, head_instr[23:5], 2'b00};

    always_comb begin
        out_pc        = '0;
        out_instr     = '0;
        out_target_b  = '0;
        out_target_cb = '0;
        if (out_valid) begin
            out_pc        = head_pc;
            out_instr     = head_instr;
            out_target_b  = head_pc + imm_b;
            out_target_cb = head_pc + imm_cb;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed bench for if_fetch_queue with DEPTH=4, RESET_PC=0x1000. The
// instruction memory is a combinational function of the address: special
// branch encodings at 0x40/0x44, an address-tagged word everywhere else.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;
    localparam logic [63:0] RST_PC  = 64'h1000;

    logic               clk;
    logic               reset;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_target_b;
    logic [ADDR_W-1:0]  out_target_cb;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    if_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_target_b  (out_target_b),
        .out_target_cb (out_target_cb)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] instr_of(input logic [63:0] a);
        if (a == 64'h40) return 32'h17FF_FFFF;
        if (a == 64'h44) return 32'hB400_0040;
        return {16'hE5A0, a[15:0]};
    endfunction

    always_comb imem_rdata = instr_of(imem_addr);

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        step();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RST_PC); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        checks++; if (out_target_b !== 64'h0 || out_target_cb !== 64'h0) begin errors++; $display("FAIL reset_targets: got %h/%h want 0/0", out_target_b, out_target_cb); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_pc = RST_PC + 64'(4 * i);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
            checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
            checks++; if (out_instr !== instr_of(exp_pc)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, instr_of(exp_pc)); end
        end
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp_head;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++; if (imem_addr !== 64'h1010) begin errors++; $display("FAIL fill_addr_4: got %h want 1010", imem_addr); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (imem_addr !== 64'h1010) begin errors++; $display("FAIL fill_addr_8: got %h want 1010", imem_addr); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h1000) begin errors++; $display("FAIL fill_head_hold: got %0b/%h want 1/1000", out_valid, out_pc); end
        for (int i = 0; i < 6; i++) exp_q.push_back(64'h1000 + 64'(4 * i));
        // Full queue with ready high: each cycle pops one and pushes one.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_head = exp_q.pop_front();
            checks++; if (out_pc !== exp_head) begin errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, out_pc, exp_head); end
            checks++; if (imem_addr !== exp_head + 64'h10) begin errors++; $display("FAIL drain_full_addr[%0d]: got %h want %h", i, imem_addr, exp_head + 64'h10); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %0b want 0", out_valid); end
        checks++; if (imem_addr !== 64'h2000) begin errors++; $display("FAIL redir_addr: got %h want 2000", imem_addr); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL redir_pc_zero: got %h want 0", out_pc); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2000) begin errors++; $display("FAIL redir_first: got %0b/%h want 1/2000", out_valid, out_pc); end
        step();
        checks++; if (out_pc !== 64'h2004) begin errors++; $display("FAIL redir_second: got %h want 2004", out_pc); end
        // Held redirect: queue stays empty, PC reloaded every cycle.
        redirect_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_pc = 64'h3000 + 64'(i * 'h105);
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_hold_valid[%0d]: got %0b want 0", i, out_valid); end
            checks++; if (imem_addr !== ((64'h3000 + 64'(i * 'h105)) & ~64'h3)) begin errors++; $display("FAIL redir_hold_addr[%0d]: got %h", i, imem_addr); end
        end
        // PC wrap at the top of the address space.
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", imem_addr); end
        checks++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL pc_wrap_head: got %h want fffffffffffffffc", out_pc); end
        out_ready = 1'b0;
    endtask

    task automatic test_targets();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        checks++; if (out_pc !== 64'h40 || out_instr !== 32'h17FF_FFFF) begin errors++; $display("FAIL tgt_head: got %h/%h want 40/17ffffff", out_pc, out_instr); end
        checks++; if (out_target_b !== 64'h3C) begin errors++; $display("FAIL tgt_b_neg: got %h want 3c", out_target_b); end
        checks++; if (out_target_cb !== 64'h3C) begin errors++; $display("FAIL tgt_cb_neg: got %h want 3c", out_target_cb); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_pc !== 64'h44 || out_instr !== 32'hB400_0040) begin errors++; $display("FAIL tgt_head2: got %h/%h want 44/b4000040", out_pc, out_instr); end
        checks++; if (out_target_cb !== 64'h4C) begin errors++; $display("FAIL tgt_cb_pos: got %h want 4c", out_target_cb); end
        checks++; if (out_target_b !== 64'h144) begin errors++; $display("FAIL tgt_b_pos: got %h want 144", out_target_b); end
        step();
        checks++; if (out_target_cb !== 64'h4C || out_pc !== 64'h44) begin errors++; $display("FAIL tgt_stall_hold: got %h/%h want 44/4c", out_pc, out_target_cb); end
    endtask

    task automatic test_reset_override();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        out_ready      = 1'b1;
        step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovr_valid: got %0b want 0", out_valid); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rst_ovr_addr: got %h want %h", imem_addr, RST_PC); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin errors++; $display("FAIL rst_ovr_first: got %0b/%h want 1/%h", out_valid, out_pc, RST_PC); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect();
        test_targets();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
